// File: rtl/mmio_io_unit_if.sv
// Data-bus port bundle between the processor datapath and the MMIO unit.
// The datapath is the master; the I/O unit decodes and answers as the slave.
interface mmio_io_unit_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] dataAddr;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] wrData;
  logic [DBITS-1:0] rdData;
  logic             ioHit;
  logic             dmemWrtEn;

  modport master (output dataAddr, isLoad, isStore, wrData,
                  input  rdData, ioHit, dmemWrtEn);
  modport slave  (input  dataAddr, isLoad, isStore, wrData,
                  output rdData, ioHit, dmemWrtEn);
endinterface

// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O unit: HEX/LED output registers, synchronised and debounced
// inputs, sticky W1C key/switch events and a maskable key interrupt.
module mmio_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_db;

  // Accepting at LAST and clearing keeps the counter from ever wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_db  <= 1'b1;
    end else if (i_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_db  <= i_sync;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_db = r_db;
endmodule

module mmio_io_unit #(
  parameter int DBITS           = 32,
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int NUM_LEDR        = 10,
  parameter int NUM_LEDG        = 8,
  parameter int HEX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_io_unit_if.slave           bus,
  input  logic [NUM_SW-1:0]       SW,
  input  logic [NUM_KEY-1:0]      KEY,
  output logic [NUM_LEDR-1:0]     LEDR,
  output logic [NUM_LEDG-1:0]     LEDG,
  output logic [4*HEX_DIGITS-1:0] hexOut,
  output logic                    irq
);
  localparam logic [7:0] OFF_HEX   = 8'h00;
  localparam logic [7:0] OFF_LEDR  = 8'h04;
  localparam logic [7:0] OFF_LEDG  = 8'h08;
  localparam logic [7:0] OFF_KDATA = 8'h10;
  localparam logic [7:0] OFF_SDATA = 8'h14;
  localparam logic [7:0] OFF_KEVT  = 8'h18;
  localparam logic [7:0] OFF_SEVT  = 8'h1C;
  localparam logic [7:0] OFF_KIE   = 8'h20;

  logic [4*HEX_DIGITS-1:0] r_hex;
  logic [NUM_LEDR-1:0]     r_ledr;
  logic [NUM_LEDG-1:0]     r_ledg;
  logic [NUM_KEY-1:0]      r_kevt, r_kie, r_key_s1, r_key_s2, r_kdb_d;
  logic [NUM_SW-1:0]       r_sevt, r_sw_s1, r_sw_s2, r_sw_d;

  logic [NUM_KEY-1:0] w_kdb, w_kset, w_kclr;
  logic [NUM_SW-1:0]  w_sset, w_sclr;
  logic [7:0]         w_off;
  logic               w_region, w_hit, w_wr;
  logic [DBITS-1:0]   w_rd;
  logic               w_unused;

  assign w_off    = bus.dataAddr[7:0];
  assign w_region = (bus.dataAddr[DBITS-1 -: 4] == 4'hF);
  assign w_hit    = (bus.isLoad | bus.isStore) & w_region;
  // A simultaneous load+store is a store; the read mux still follows the address.
  assign w_wr     = bus.isStore & w_region;
  assign w_unused = ^{bus.dataAddr[DBITS-5:8], bus.wrData};

  assign bus.ioHit     = w_hit;
  assign bus.dmemWrtEn = bus.isStore & ~w_region;
  assign bus.rdData    = w_rd;

  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_off)
        OFF_HEX:   w_rd[4*HEX_DIGITS-1:0] = r_hex;
        OFF_LEDR:  w_rd[NUM_LEDR-1:0]     = r_ledr;
        OFF_LEDG:  w_rd[NUM_LEDG-1:0]     = r_ledg;
        OFF_KDATA: w_rd[NUM_KEY-1:0]      = w_kdb;
        OFF_SDATA: w_rd[NUM_SW-1:0]       = r_sw_s2;
        OFF_KEVT:  w_rd[NUM_KEY-1:0]      = r_kevt;
        OFF_SEVT:  w_rd[NUM_SW-1:0]       = r_sevt;
        OFF_KIE:   w_rd[NUM_KEY-1:0]      = r_kie;
        default:   w_rd = '0;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEY; gi++) begin : g_key
      mmio_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk    (clk),
        .reset  (reset),
        .i_sync (r_key_s2[gi]),
        .o_db   (w_kdb[gi])
      );
    end
  endgenerate

  // Events are edges of the already-conditioned values, one cycle behind them.
  assign w_kset = r_kdb_d & ~w_kdb;
  assign w_sset = r_sw_s2 ^ r_sw_d;
  assign w_kclr = (w_wr && w_off == OFF_KEVT) ? bus.wrData[NUM_KEY-1:0] : '0;
  assign w_sclr = (w_wr && w_off == OFF_SEVT) ? bus.wrData[NUM_SW-1:0]  : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hex    <= '0;
      r_ledr   <= '0;
      r_ledg   <= '0;
      r_kie    <= '0;
      r_kevt   <= '0;
      r_sevt   <= '0;
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_kdb_d  <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_sw_d   <= '0;
    end else begin
      r_key_s1 <= KEY;
      r_key_s2 <= r_key_s1;
      r_kdb_d  <= w_kdb;
      r_sw_s1  <= SW;
      r_sw_s2  <= r_sw_s1;
      r_sw_d   <= r_sw_s2;
      // Hardware set dominates a same-cycle software clear.
      r_kevt   <= (r_kevt & ~w_kclr) | w_kset;
      r_sevt   <= (r_sevt & ~w_sclr) | w_sset;
      if (w_wr) begin
        case (w_off)
          OFF_HEX:  r_hex  <= bus.wrData[4*HEX_DIGITS-1:0];
          OFF_LEDR: r_ledr <= bus.wrData[NUM_LEDR-1:0];
          OFF_LEDG: r_ledg <= bus.wrData[NUM_LEDG-1:0];
          OFF_KIE:  r_kie  <= bus.wrData[NUM_KEY-1:0];
          default:  ;
        endcase
      end
    end
  end

  assign LEDR   = r_ledr;
  assign LEDG   = r_ledg;
  assign hexOut = r_hex;
  assign irq    = |(r_kevt & r_kie);
endmodule

// File: tb/tb_mmio_io_unit.sv
// Scoreboard bench for mmio_io_unit: expected values are queued as stimulus is
// driven and popped when the matching DUT output is sampled.
module tb_mmio_io_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  SW = '0;
  logic [3:0]  KEY = '1;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [15:0] hexOut;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  mmio_io_unit_if #(.DBITS(32)) bus();

  mmio_io_unit #(
    .DBITS(32), .NUM_SW(10), .NUM_KEY(4), .NUM_LEDR(10), .NUM_LEDG(8),
    .HEX_DIGITS(4), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .hexOut(hexOut), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    bus.isLoad = 1'b0; bus.isStore = 1'b0; bus.dataAddr = '0; bus.wrData = '0;
  endtask

  task automatic drv_load(input logic [31:0] a);
    bus.isLoad = 1'b1; bus.isStore = 1'b0; bus.dataAddr = a; bus.wrData = '0;
  endtask

  task automatic drv_store(input logic [31:0] a, input logic [31:0] d);
    bus.isLoad = 1'b0; bus.isStore = 1'b1; bus.dataAddr = a; bus.wrData = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [8];
    logic [31:0] exps  [8];
    logic [31:0] e;
    addrs = '{32'hF0000000, 32'hF0000004, 32'hF0000008, 32'hF0000018,
              32'hF000001C, 32'hF0000020, 32'hF0000010, 32'hF0000014};
    exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0};
    idle();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({hexOut, LEDR, LEDG, irq} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hex=%h ledr=%h ledg=%h irq=%b, want all 0", hexOut, LEDR, LEDG, irq);
    end
    reset = 1'b1;
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back(exps[i]);
    for (int i = 0; i < 8; i++) begin
      drv_load(addrs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.ioHit, bus.rdData} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL reset_read[%h]: got hit=%b rd=%h, want hit=1 rd=%h", addrs[i], bus.ioHit, bus.rdData, e);
      end
      step();
    end
    idle();
  endtask

  task automatic test_store();
    logic [31:0] addrs [3];
    logic [31:0] data  [3];
    logic [31:0] e;
    addrs = '{32'hF0000000, 32'hF0000004, 32'hF0000008};
    data  = '{32'h1234, 32'h3FF, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      drv_store(addrs[i], data[i]);
      @(negedge clk);
      n_tests++;
      if ({bus.dmemWrtEn, bus.ioHit} !== 2'b01) begin
        n_fail++;
        $display("FAIL store_io_strobes[%0d]: got dmem=%b hit=%b, want dmem=0 hit=1", i, bus.dmemWrtEn, bus.ioHit);
      end
      step();
    end
    idle();
    n_tests++;
    if ({hexOut, LEDR, LEDG} !== {16'h1234, 10'h3FF, 8'hFF}) begin
      n_fail++;
      $display("FAIL store_regs: got hex=%h ledr=%h ledg=%h, want 1234/3ff/ff", hexOut, LEDR, LEDG);
    end
    exp_q.push_back(32'h1234); exp_q.push_back(32'h3FF); exp_q.push_back(32'hFF);
    for (int i = 0; i < 3; i++) begin
      drv_load(addrs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_tests++;
      if (bus.rdData !== e) begin
        n_fail++;
        $display("FAIL readback[%h]: got %h, want %h", addrs[i], bus.rdData, e);
      end
      step();
    end
    drv_store(32'h00000100, 32'hFFFFFFFF);
    @(negedge clk);
    n_tests++;
    if ({bus.dmemWrtEn, bus.ioHit, bus.rdData} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL dmem_store: got dmem=%b hit=%b rd=%h, want dmem=1 hit=0 rd=0", bus.dmemWrtEn, bus.ioHit, bus.rdData);
    end
    step();
    idle();
    n_tests++;
    if ({hexOut, LEDR, LEDG} !== {16'h1234, 10'h3FF, 8'hFF}) begin
      n_fail++;
      $display("FAIL dmem_no_io_change: got hex=%h ledr=%h ledg=%h, want 1234/3ff/ff", hexOut, LEDR, LEDG);
    end
    // Bits [27:8] are don't-care in the decode.
    drv_store(32'hF1234504, 32'h2AA);
    step();
    idle();
    n_tests++;
    if (LEDR !== 10'h2AA) begin
      n_fail++;
      $display("FAIL alias_store: got ledr=%h, want 2aa", LEDR);
    end
    bus.isLoad = 1'b1; bus.isStore = 1'b1; bus.dataAddr = 32'hF0000008; bus.wrData = 32'h5A;
    @(negedge clk);
    n_tests++;
    if ({bus.dmemWrtEn, bus.rdData} !== {1'b0, 32'hFF}) begin
      n_fail++;
      $display("FAIL ldst_read: got dmem=%b rd=%h, want dmem=0 rd=ff", bus.dmemWrtEn, bus.rdData);
    end
    step();
    idle();
    n_tests++;
    if (LEDG !== 8'h5A) begin
      n_fail++;
      $display("FAIL ldst_write: got ledg=%h, want 5a", LEDG);
    end
  endtask

  task automatic test_debounce();
    int n;
    logic found;
    logic [31:0] e;
    KEY = 4'b1011;
    repeat (10) step();
    KEY = 4'b1111;
    repeat (25) step();
    exp_q.push_back(32'hF); exp_q.push_back(32'h0);
    drv_load(32'hF0000010);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL bounce_kdata: got %h, want %h", bus.rdData, e);
    end
    drv_load(32'hF0000018);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL bounce_kevt: got %h, want %h", bus.rdData, e);
    end
    step();
    KEY = 4'b1011;
    drv_load(32'hF0000010);
    exp_q.push_back(32'd18);
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.rdData === 32'hB) found = 1'b1;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (n !== int'(e)) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles, want %0d", n, e);
    end
    drv_load(32'hF0000018);
    #1;
    n_tests++;
    if (bus.rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL kevt_early: got %h, want 0", bus.rdData);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.rdData !== 32'h4) begin
      n_fail++;
      $display("FAIL kevt_set: got %h, want 4", bus.rdData);
    end
    step();
    idle();
  endtask

  task automatic test_irq();
    drv_store(32'hF0000020, 32'h4);
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_before_kie: got %b, want 0", irq);
    end
    step();
    idle();
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got %b, want 1", irq);
    end
    step();
    drv_store(32'hF0000018, 32'h4);
    step();
    drv_load(32'hF0000018);
    @(negedge clk);
    n_tests++;
    if ({irq, bus.rdData} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL w1c_clear: got irq=%b kevt=%h, want irq=0 kevt=0", irq, bus.rdData);
    end
    step();
    KEY = 4'b1111;
    repeat (25) step();
    @(negedge clk);
    n_tests++;
    if (bus.rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL release_no_event: got kevt=%h, want 0", bus.rdData);
    end
    step();
    KEY = 4'b1011;
    repeat (18) step();
    drv_store(32'hF0000018, 32'h4);
    @(negedge clk);
    n_tests++;
    if (bus.rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL collide_pre: got kevt=%h, want 0", bus.rdData);
    end
    step();
    drv_load(32'hF0000018);
    @(negedge clk);
    n_tests++;
    if ({irq, bus.rdData} !== {1'b1, 32'h4}) begin
      n_fail++;
      $display("FAIL collide_set_wins: got irq=%b kevt=%h, want irq=1 kevt=4", irq, bus.rdData);
    end
    step();
    idle();
  endtask

  task automatic test_sw();
    logic [31:0] e;
    drv_load(32'hF0000014);
    SW = 10'h001;
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h1);
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL sdata_1cyc: got %h, want %h", bus.rdData, e);
    end
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL sdata_2cyc: got %h, want %h", bus.rdData, e);
    end
    drv_load(32'hF000001C);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL sevt_2cyc: got %h, want %h", bus.rdData, e);
    end
    @(posedge clk); @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (bus.rdData !== e) begin
      n_fail++;
      $display("FAIL sevt_3cyc: got %h, want %h", bus.rdData, e);
    end
    step();
    drv_store(32'hF000001C, 32'h1);
    step();
    drv_load(32'hF000001C);
    @(negedge clk);
    n_tests++;
    if (bus.rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL sevt_w1c: got %h, want 0", bus.rdData);
    end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    drv_store(32'hF0000004, 32'h155);
    step();
    drv_store(32'hF0000018, 32'hF);
    step();
    drv_store(32'hF0000020, 32'h3);
    step();
    idle();
    KEY = 4'b1100;
    repeat (20) step();
    drv_load(32'hF0000018);
    @(negedge clk);
    n_tests++;
    if ({irq, LEDR, bus.rdData} !== {1'b1, 10'h155, 32'h3}) begin
      n_fail++;
      $display("FAIL pre_reset: got irq=%b ledr=%h kevt=%h, want 1/155/3", irq, LEDR, bus.rdData);
    end
    #2;
    KEY = 4'b1111;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({hexOut, LEDR, LEDG, irq, bus.rdData} !== 67'h0) begin
      n_fail++;
      $display("FAIL async_reset: got hex=%h ledr=%h ledg=%h irq=%b kevt=%h, want all 0", hexOut, LEDR, LEDG, irq, bus.rdData);
    end
    repeat (2) step();
    reset = 1'b1;
    repeat (25) step();
    drv_load(32'hF0000040);
    @(negedge clk);
    n_tests++;
    if ({bus.ioHit, bus.rdData} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL unmapped_read: got hit=%b rd=%h, want hit=1 rd=0", bus.ioHit, bus.rdData);
    end
    drv_load(32'hF0000018);
    #1;
    n_tests++;
    if (bus.rdData !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_kevt: got %h, want 0", bus.rdData);
    end
    drv_load(32'hF0000010);
    #1;
    n_tests++;
    if (bus.rdData !== 32'hF) begin
      n_fail++;
      $display("FAIL post_reset_kdata: got %h, want f", bus.rdData);
    end
    step();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_store();
    test_debounce();
    test_irq();
    test_sw();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
